param_updown_counter: RTL

- Parametrised successor to the team's 8-bit enable-gated up counter.
- Adds configurable width and modulus, up/down direction, and synchronous load/clear.
- Adds wrap or saturate boundary mode and a terminal-count pulse.
- Used as the general-purpose event/timer counter in datapath and control blocks. Feeds the same consumers as the 8-bit counter when WIDTH=8 and MAX_VALUE=255.

---
 rtl/param_updown_counter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down event/timer counter.
// Configurable width and modulus (0..MAX_VALUE), wrap or saturate at the
// bounds, synchronous clear/load (load clamps to MAX_VALUE) and a
// registered one-cycle terminal-count pulse.
// Optional feature macro: COUNTER_PRESCALE_EN -- when defined, a count step
// happens only once every PRESCALE enabled cycles.
module param_updown_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0,
  parameter int unsigned      PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // Reject illegal configurations at elaboration time.
  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be 2..32");
  end
  if (MAX_VALUE == ZERO) begin : g_bad_max
    $error("param_updown_counter: MAX_VALUE must be >= 1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_updown_counter: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             step_s;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned       PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] pre_q, pre_d;

  // Prescaler: clear/load restart it; a step fires on the last enabled tick.
  always_comb begin
    pre_d  = pre_q;
    step_s = 1'b0;
    if (clear || load) begin
      pre_d = {PRE_W{1'b0}};
    end else if (enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = {PRE_W{1'b0}};
        step_s = 1'b1;
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // Prescale counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= {PRE_W{1'b0}};
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  // Without the prescaler every enabled cycle is a count step.
  always_comb begin
    step_s = enable;
  end
`endif

  // Next count and terminal-count pulse; clear > load > step, bounds checked
  // before any arithmetic so no implicit overflow is relied upon.
  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    if (clear) begin
      out_d = ZERO;
    end else if (load) begin
      out_d = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
    end else if (step_s) begin
      if (up_dn) begin
        if (out_q < MAX_VALUE) begin
          out_d = out_q + ONE;
          tc_d  = SATURATE && (out_q == (MAX_VALUE - ONE));
        end else if (!SATURATE) begin
          out_d = ZERO;
          tc_d  = 1'b1;
        end else begin
          out_d = out_q;
        end
      end else begin
        if (out_q != ZERO) begin
          out_d = out_q - ONE;
          tc_d  = SATURATE && (out_q == ONE);
        end else if (!SATURATE) begin
          out_d = MAX_VALUE;
          tc_d  = 1'b1;
        end else begin
          out_d = out_q;
        end
      end
    end else begin
      out_d = out_q;
    end
  end

  // Count and tc registers; reset wins over every other action.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= ZERO;
      tc_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
    end
  end

  assign out     = out_q;
  assign tc      = tc_q;
  assign at_max  = (out_q == MAX_VALUE);
  assign at_zero = (out_q == ZERO);

endmodule
